// File: rtl/draw_text_attr.sv
// ============================================================================
// draw_text_attr: centred text-box overlay with per-frame attribute
// (steady / blink / inverse-blink / dim) and vsync-driven blink timer.
// Optional macro: DRAW_TEXT_SHADOW_EN adds a one-pixel right drop shadow.
// Rev 1.0
// ============================================================================
`default_nettype none

module draw_text_attr #(
  parameter int          X_ADDR_WIDTH = 1,
  parameter int          Y_ADDR_WIDTH = 1,
  parameter int          SCALE_COEFF  = 0,
  parameter int          X_CHAR_COUNT = 1,
  parameter int          Y_CHAR_COUNT = 1,
  parameter int          X_MIN        = 0,
  parameter int          X_MAX        = 0,
  parameter int          Y_MIN        = 0,
  parameter int          Y_MAX        = 0,
  parameter logic [11:0] FG_COLOR     = 12'hfff,
  parameter logic [3:0]  DIM_STEP     = 4'h1,
  parameter int          BLINK_FRAMES = 30,
  parameter int          CNT_WIDTH    = 6
) (
  input  logic                             i_pclk,
  input  logic                             i_rst,
  input  logic [11:0]                      i_hcount,
  input  logic [11:0]                      i_vcount,
  input  logic                             i_hsync,
  input  logic                             i_hblnk,
  input  logic                             i_vsync,
  input  logic                             i_vblnk,
  input  logic [11:0]                      i_rgb,
  input  logic [7:0]                       i_rom_word,
  input  logic [1:0]                       i_mode,
  input  logic                             i_enable,
  output logic [11:0]                      o_hcount,
  output logic [11:0]                      o_vcount,
  output logic                             o_hsync,
  output logic                             o_hblnk,
  output logic                             o_vsync,
  output logic                             o_vblnk,
  output logic [11:0]                      o_rgb,
  output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] o_char_addr,
  output logic [3:0]                       o_char_line,
  output logic                             o_blink_phase
);

  localparam int          c_BOX_W = X_CHAR_COUNT * (8 << SCALE_COEFF);
  localparam int          c_BOX_H = Y_CHAR_COUNT * (16 << SCALE_COEFF);
  localparam logic [11:0] c_XPOS  = 12'(((X_MAX - X_MIN - c_BOX_W) >> 1) + X_MIN);
  localparam logic [11:0] c_YPOS  = 12'(((Y_MAX - Y_MIN - c_BOX_H) >> 1) + Y_MIN);
  localparam logic [11:0] c_W12   = 12'(c_BOX_W);
  localparam logic [11:0] c_H12   = 12'(c_BOX_H);
  localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [11:0] hc;
    logic [11:0] vc;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
    logic        inbox;
    logic [2:0]  idx;
  } pix_t;

  logic [11:0]          w_hrel;
  logic [11:0]          w_vrel;
  pix_t                 w_s0;
  pix_t                 r_s1;
  pix_t                 r_s2;
  logic                 r_vsync_d;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [1:0]           r_frame_mode;
  logic                 r_frame_en;
  logic                 w_glyph;
  logic                 w_fg;
  logic                 w_vis;
  logic [11:0]          w_bg;
  logic [11:0]          w_rgb_next;

  function automatic logic [3:0] f_dim(input logic [3:0] c);
    return (c < DIM_STEP) ? 4'h0 : c - DIM_STEP;
  endfunction

  assign w_hrel      = i_hcount - c_XPOS;
  assign w_vrel      = i_vcount - c_YPOS;
  assign o_char_addr = {w_vrel[Y_ADDR_WIDTH+3+SCALE_COEFF:4+SCALE_COEFF],
                        w_hrel[X_ADDR_WIDTH+2+SCALE_COEFF:3+SCALE_COEFF]};

  always_comb begin
    w_s0       = '0;
    w_s0.hc    = i_hcount;
    w_s0.vc    = i_vcount;
    w_s0.hs    = i_hsync;
    w_s0.hb    = i_hblnk;
    w_s0.vs    = i_vsync;
    w_s0.vb    = i_vblnk;
    w_s0.rgb   = i_rgb;
    w_s0.inbox = (w_hrel < c_W12) && (w_vrel < c_H12);
    w_s0.idx   = w_hrel[2+SCALE_COEFF:SCALE_COEFF];
  end

  // The ROM word arrives aligned with stage 2, so the decision is made there.
  always_comb begin
    w_glyph = i_rom_word[3'd7 - r_s2.idx];
    w_fg    = 1'b0;
    w_bg    = r_s2.rgb;
    case (r_frame_mode)
      2'b00: w_fg = w_glyph;
      2'b01: w_fg = w_glyph & o_blink_phase;
      2'b10: w_fg = o_blink_phase ? w_glyph : ~w_glyph;
      default: begin
        w_fg = w_glyph;
        w_bg = {f_dim(r_s2.rgb[11:8]), f_dim(r_s2.rgb[7:4]), f_dim(r_s2.rgb[3:0])};
      end
    endcase
    w_vis = w_glyph & ((r_frame_mode[1] ^ r_frame_mode[0]) ? o_blink_phase : 1'b1);
  end

`ifdef DRAW_TEXT_SHADOW_EN
  logic r_shadow;

  always_ff @(posedge i_pclk) begin
    if (i_rst || r_s2.hb) r_shadow <= 1'b0;
    else                  r_shadow <= r_s2.inbox & r_frame_en & w_vis;
  end

  always_comb begin
    w_rgb_next = r_s2.rgb;
    if (r_s2.hb || r_s2.vb)                w_rgb_next = 12'h000;
    else if (!r_s2.inbox || !r_frame_en)   w_rgb_next = r_s2.rgb;
    else if (w_fg)                         w_rgb_next = FG_COLOR;
    else if (!w_glyph && r_shadow)         w_rgb_next = 12'h000;
    else                                   w_rgb_next = w_bg;
  end
`else
  always_comb begin
    w_rgb_next = r_s2.rgb;
    if (r_s2.hb || r_s2.vb)                w_rgb_next = 12'h000;
    else if (!r_s2.inbox || !r_frame_en)   w_rgb_next = r_s2.rgb;
    else if (w_fg)                         w_rgb_next = FG_COLOR;
    else                                   w_rgb_next = w_bg;
  end
`endif

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_s1        <= '0;
      r_s2        <= '0;
      o_hcount    <= '0;
      o_vcount    <= '0;
      o_hsync     <= 1'b0;
      o_hblnk     <= 1'b0;
      o_vsync     <= 1'b0;
      o_vblnk     <= 1'b0;
      o_rgb       <= '0;
      o_char_line <= '0;
    end else begin
      r_s1        <= w_s0;
      r_s2        <= r_s1;
      o_hcount    <= r_s2.hc;
      o_vcount    <= r_s2.vc;
      o_hsync     <= r_s2.hs;
      o_hblnk     <= r_s2.hb;
      o_vsync     <= r_s2.vs;
      o_vblnk     <= r_s2.vb;
      o_rgb       <= w_rgb_next;
      o_char_line <= w_vrel[3+SCALE_COEFF:SCALE_COEFF];
    end
  end

  // Frame attributes are sampled only at the vsync edge to avoid tearing.
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_vsync_d     <= 1'b0;
      r_cnt         <= '0;
      o_blink_phase <= 1'b1;
      r_frame_mode  <= 2'b00;
      r_frame_en    <= 1'b0;
    end else begin
      r_vsync_d <= i_vsync;
      if (i_vsync && !r_vsync_d) begin
        r_frame_mode <= i_mode;
        r_frame_en   <= i_enable;
        if (r_cnt == c_CNT_LAST) begin
          r_cnt         <= '0;
          o_blink_phase <= ~o_blink_phase;
        end else begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire
